// File: rtl/l3_world_store_pkg.sv
// Shared world types used by the L3 world store and its requesters.
//   BlockPos  : packed {x, y, z} voxel position. Each coordinate is unsigned and
//               wider than the world extent, so out-of-world positions can be named.
//   BlockType : stored voxel kind.
//   BLOCK_AIR : empty voxel. This is the power-up RAM contents and the value
//               returned for out-of-range lookups.
package l3_world_store_pkg;

    localparam int COORD_W = 8;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
        coord_t z;
    } BlockPos;

    typedef logic [3:0] BlockType;

    localparam BlockType BLOCK_AIR = 4'd0;

endpackage

// File: rtl/l3_world_store_bram.sv
// world_bram: single-port, read-first block RAM with LAT output pipeline registers.
//   clk   : clock
//   we    : write enable for the addressed word
//   addr  : word address. It is sampled every cycle and read data always flows.
//   wdata : write data
//   rdata : contents of addr as they were before any same-cycle write,
//           valid LAT cycles after addr was presented
// The data path has no reset. The BRAM is expected to power up zeroed, which
// means BLOCK_AIR everywhere.
module world_bram #(
    parameter int AW    = 12,
    parameter int WIDTH = 4,
    parameter int LAT   = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem  [DEPTH];
    logic [WIDTH-1:0] pipe [LAT];

    always_ff @(posedge clk) begin
        pipe[0] <= mem[addr];           // read-first: old word is captured
        if (we) mem[addr] <= wdata;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    assign rdata = pipe[LAT-1];

endmodule

// File: rtl/l3_world_store.sv
// l3_world_store: L3 responder below l2_cache. It owns the voxel world RAM.
//   clk_in, rst_in             : clock, asynchronous active-low reset
//   l3_addr, l3_read_enable    : level-held lookup request
//   l3_out, l3_valid           : looked-up block and its one-cycle strobe
//   wr_en, wr_addr, wr_data    : loader write request
//   wr_ready                   : the write is taken on wr_en && wr_ready
// Reads and writes share the single RAM port. When both are pending, last_rd
// alternates the grant so that neither side starves.
module l3_world_store
    import l3_world_store_pkg::*;
#(
    parameter int XB      = 4,
    parameter int YB      = 4,
    parameter int ZB      = 4,
    parameter int RAM_LAT = 2
) (
    input  logic     clk_in,
    input  logic     rst_in,
    input  BlockPos  l3_addr,
    input  logic     l3_read_enable,
    output BlockType l3_out,
    output logic     l3_valid,
    input  logic     wr_en,
    input  BlockPos  wr_addr,
    input  BlockType wr_data,
    output logic     wr_ready
);

    localparam int AW = XB + YB + ZB;
    localparam int CW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_RESP,
        S_WRITE,
        S_COOLDOWN
    } state_t;

    function automatic logic in_range(input BlockPos p);
        return ((p.x >> XB) == '0) && ((p.y >> YB) == '0) && ((p.z >> ZB) == '0);
    endfunction

    function automatic logic [AW-1:0] ram_idx(input BlockPos p);
        return {p.y[YB-1:0], p.z[ZB-1:0], p.x[XB-1:0]};
    endfunction

    state_t          state, state_d;
    logic            last_rd;
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   rd_idx_q, wr_idx_q;
    BlockType        wr_data_q;
    logic            wr_ok_q;

    logic            rd_grant, wr_grant, rd_ok;
    logic            ram_we;
    logic [AW-1:0]   ram_addr;
    BlockType        ram_rdata;

    assign rd_ok = in_range(l3_addr);

    always_comb begin
        state_d  = state;
        wr_ready = 1'b0;
        l3_valid = 1'b0;
        rd_grant = 1'b0;
        wr_grant = 1'b0;
        ram_we   = 1'b0;
        ram_addr = rd_idx_q;
        unique case (state)
            S_IDLE: begin
                wr_ready = !(l3_read_enable && !last_rd);
                rd_grant = l3_read_enable && !(wr_en && last_rd);
                wr_grant = wr_en && wr_ready;
                // The read address goes to the RAM in the grant cycle, so the data
                // emerges RAM_LAT edges after acceptance.
                ram_addr = ram_idx(l3_addr);
                if (rd_grant)      state_d = rd_ok ? S_READ : S_RESP;
                else if (wr_grant) state_d = S_WRITE;
            end
            S_READ:     if (cnt == '0) state_d = S_RESP;
            S_RESP: begin
                l3_valid = 1'b1;
                state_d  = S_COOLDOWN;
            end
            // The request is ignored for one cycle so that a level still held from
            // the previous response is not served twice.
            S_COOLDOWN: state_d = S_IDLE;
            S_WRITE: begin
                ram_addr = wr_idx_q;
                ram_we   = wr_ok_q;   // out-of-range writes are accepted and dropped
                state_d  = S_IDLE;
            end
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state     <= S_IDLE;
            last_rd   <= 1'b0;
            cnt       <= '0;
            l3_out    <= BLOCK_AIR;
            rd_idx_q  <= '0;
            wr_idx_q  <= '0;
            wr_data_q <= BLOCK_AIR;
            wr_ok_q   <= 1'b0;
        end else begin
            state <= state_d;
            if (rd_grant) begin
                rd_idx_q <= ram_idx(l3_addr);
                last_rd  <= 1'b1;
                cnt      <= CW'(RAM_LAT - 1);
                if (!rd_ok) l3_out <= BLOCK_AIR;
            end else if (wr_grant) begin
                wr_idx_q  <= ram_idx(wr_addr);
                wr_data_q <= wr_data;
                wr_ok_q   <= in_range(wr_addr);
                last_rd   <= 1'b0;
            end
            if (state == S_READ) begin
                if (cnt == '0) l3_out <= ram_rdata;
                else           cnt    <= cnt - 1'b1;
            end
        end
    end

    world_bram #(
        .AW    (AW),
        .WIDTH ($bits(BlockType)),
        .LAT   (RAM_LAT)
    ) u_bram (
        .clk   (clk_in),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wr_data_q),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_l3_world_store.sv
// Self-checking bench for l3_world_store. A coordinate-indexed world model
// predicts every lookup.
module tb_l3_world_store;
    import l3_world_store_pkg::*;

    localparam int XB = 4, YB = 4, ZB = 4, LAT = 2;

    logic     clk_in = 1'b0;
    logic     rst_in = 1'b1;
    BlockPos  l3_addr = '0;
    logic     l3_read_enable = 1'b0;
    BlockType l3_out;
    logic     l3_valid;
    logic     wr_en = 1'b0;
    BlockPos  wr_addr = '0;
    BlockType wr_data = '0;
    logic     wr_ready;

    l3_world_store #(.XB(XB), .YB(YB), .ZB(ZB), .RAM_LAT(LAT)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .l3_addr(l3_addr), .l3_read_enable(l3_read_enable),
        .l3_out(l3_out), .l3_valid(l3_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready)
    );

    always #5 clk_in = ~clk_in;

    int n_tests = 0, n_fail = 0;
    BlockType mdl [16][16][16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic BlockPos pos(input int x, input int y, input int z);
        BlockPos p;
        p.x = coord_t'(x); p.y = coord_t'(y); p.z = coord_t'(z);
        return p;
    endfunction

    function automatic bit oor(input BlockPos p);
        return (p.x >= 16) || (p.y >= 16) || (p.z >= 16);
    endfunction

    function automatic BlockType ref_rd(input BlockPos p);
        return oor(p) ? BLOCK_AIR : mdl[p.x][p.y][p.z];
    endfunction

    task automatic tick();
        @(posedge clk_in); #1;
    endtask

    // The store is expected to be idle on entry, and it is idle again on return.
    task automatic do_read(input BlockPos p, input string tag);
        int cyc = 0;
        bit got = 0;
        l3_addr = p; l3_read_enable = 1'b1;
        while (!got && cyc < 50) begin
            tick(); cyc++;
            if (l3_valid) got = 1;
        end
        check({tag, "_lat"}, cyc, oor(p) ? 1 : LAT + 1);
        if (got) check({tag, "_data"}, l3_out, ref_rd(p));
        l3_read_enable = 1'b0;
        tick(); check({tag, "_pulse"}, l3_valid, 0);
        tick();
    endtask

    task automatic do_write(input BlockPos p, input BlockType d);
        int cyc = 0;
        bit acc = 0;
        wr_addr = p; wr_data = d; wr_en = 1'b1;
        while (!acc && cyc < 50) begin
            acc = wr_ready; tick(); cyc++;
        end
        check("wr_acc", acc, 1);
        wr_en = 1'b0;
        if (acc && !oor(p)) mdl[p.x][p.y][p.z] = d;
        tick();
    endtask

    task automatic do_reset();
        rst_in = 1'b0; tick(); tick();
        check("rst_valid", l3_valid, 0);
        check("rst_out", l3_out, BLOCK_AIR);
        rst_in = 1'b1; tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int last_ev, n_r, n_w, viol, first_ev, last_v, n_v, gap_bad;
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                for (int k = 0; k < 16; k++) mdl[i][j][k] = BLOCK_AIR;

        #2;
        do_reset();
        check("rst_wr_ready", wr_ready, 1);

        // Directed lookups and writes, including the out-of-range cases.
        do_read(pos(1, 2, 3), "rd_123_air");
        do_write(pos(1, 2, 3), 4'd5);
        do_read(pos(1, 2, 3), "rd_123_5");
        do_read(pos(3, 2, 1), "rd_321");
        do_read(pos(16, 0, 0), "rd_oor_x");
        do_write(pos(0, 16, 0), 4'd7);
        for (int x = 0; x < 4; x++)
            for (int y = 0; y < 16; y++) do_read(pos(x, y, 0), "sweep");

        // Both requests held from reset: the grants must alternate, read first.
        rst_in = 1'b0;
        l3_addr = pos(4, 4, 4); l3_read_enable = 1'b1;
        wr_addr = pos(2, 2, 2); wr_data = 4'd9; wr_en = 1'b1;
        tick();
        rst_in = 1'b1;
        last_ev = -1; first_ev = -1; n_r = 0; n_w = 0; viol = 0;
        for (int c = 0; c < 40; c++) begin
            if (l3_valid) begin
                check("alt_rd_data", l3_out, ref_rd(l3_addr));
                if (last_ev == 0) viol++;
                if (first_ev < 0) first_ev = 0;
                last_ev = 0; n_r++;
            end
            if (wr_ready) begin
                if (last_ev == 1) viol++;
                if (first_ev < 0) first_ev = 1;
                last_ev = 1; n_w++;
                mdl[2][2][2] = 4'd9;
            end
            tick();
        end
        wr_en = 1'b0; l3_read_enable = 1'b0;
        check("alt_first_read", first_ev, 0);
        check("alt_violations", viol, 0);
        check("alt_reads_ge3", n_r >= 3, 1);
        check("alt_writes_ge3", n_w >= 3, 1);
        for (int c = 0; c < 8; c++) tick();
        do_read(pos(2, 2, 2), "alt_wr_landed");

        // A read level held past its response is re-served only after the cooldown.
        l3_addr = pos(1, 2, 3); l3_read_enable = 1'b1;
        last_v = -1; n_v = 0; gap_bad = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (l3_valid) begin
                check("hold_data", l3_out, ref_rd(l3_addr));
                if (last_v >= 0 && (c - last_v) < LAT + 2) gap_bad++;
                last_v = c; n_v++;
            end
        end
        l3_read_enable = 1'b0;
        check("hold_two_resp", n_v >= 2, 1);
        check("hold_spacing", gap_bad, 0);
        for (int c = 0; c < 8; c++) tick();

        // Reset while READ is in progress.
        l3_addr = pos(1, 2, 3); l3_read_enable = 1'b1;
        tick(); tick();
        rst_in = 1'b0; #1;
        check("midrst_valid_now", l3_valid, 0);
        l3_read_enable = 1'b0;
        tick();
        rst_in = 1'b1;
        check("midrst_wr_ready", wr_ready, 1);
        n_v = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (l3_valid) n_v++;
        end
        check("midrst_no_resp", n_v, 0);
        do_read(pos(1, 2, 3), "midrst_reissue");

        // Random traffic, concentrated on a small set of cells so that writes are re-read.
        for (int n = 0; n < 200; n++) begin
            BlockPos p;
            if ($urandom_range(0, 3) == 0)
                p = pos($urandom_range(0, 17), $urandom_range(0, 17), $urandom_range(0, 17));
            else
                p = pos($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
            if ($urandom_range(0, 1) == 0) do_write(p, BlockType'($urandom_range(0, 15)));
            else                           do_read(p, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
